board_cmd_sequencer: RTL and testbench

- Sits between the board buttons/switches and the CPU_top debug command port.
- Converts raw button presses into single, handshaked CPU commands (write, read, step), using the switch values latched at press time.
- Captures the CPU's response into a display register that feeds the seven-segment scanner.
- Flags commands that never complete via a timeout error.

---
 rtl/board_cmd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_board_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_cmd_sequencer.sv
// Board command sequencer: turns debounced button presses into handshaked
// CPU debug commands and captures the CPU response for the display.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an accepted button press
// S_REQ  | cmd_valid asserted, holding the command until cmd_ready
// S_WAIT | command accepted, waiting for rsp_valid or the timeout
module board_cmd_sequencer #(
    parameter int DEB_CYCLES = 1000000,
    parameter int TIMEOUT    = 255,
    parameter int AW         = 8,
    parameter int DW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_wr,
    input  logic          btn_rd,
    input  logic          btn_step,
    input  logic [AW-1:0] sw_addr,
    input  logic [DW-1:0] sw_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [31:0]   cmd_addr,
    output logic [31:0]   cmd_data,
    input  logic          rsp_valid,
    input  logic [15:0]   rsp_data,
    output logic [15:0]   disp_data,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t        state;
    logic [2:0]    raw_btn;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [CW-1:0] deb_cnt [3];
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    sel_op;

    // bit 0 = write, bit 1 = read, bit 2 = step (also the priority order)
    assign raw_btn = {btn_step, btn_rd, btn_wr};

    // Synchronize, debounce and edge-detect all three buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw_btn;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Fixed-priority pick among same-cycle presses; losers are discarded.
    always_comb begin
        sel_op = OP_NOP;
        if (press[0]) begin
            sel_op = OP_WRITE;
        end else if (press[1]) begin
            sel_op = OP_READ;
        end else if (press[2]) begin
            sel_op = OP_STEP;
        end
    end

    // Command FSM with registered outputs; presses outside IDLE are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NOP;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            disp_data <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_op != OP_NOP) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= sel_op;
                        cmd_addr  <= (sel_op == OP_STEP) ? 32'd0 : 32'(sw_addr);
                        cmd_data  <= (sel_op == OP_STEP) ? 32'd0 : 32'(sw_data);
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_op    <= OP_NOP;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // a response on the final timeout cycle still wins
                    if (rsp_valid) begin
                        disp_data <= rsp_data;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err       <= 1'b1;
                        disp_data <= 16'hEEEE;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    cmd_op    <= OP_NOP;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_cmd_sequencer.sv
// Self-checking bench for board_cmd_sequencer (DEB_CYCLES=4, TIMEOUT=16).
module tb_board_cmd_sequencer;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_wr, btn_rd, btn_step;
    logic [7:0]  sw_addr;
    logic [5:0]  sw_data;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] disp_data;
    logic        busy, err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t sb[$];

    typedef struct {
        int          sel;      // 0 write, 1 read, 2 step
        logic [7:0]  addr;
        logic [5:0]  data;
        int          rdy_dly;  // cycles of cmd_ready low while cmd_valid
        int          rsp_dly;  // cycles in WAIT before rsp_valid, -1 = none
        logic [15:0] rsp_val;
        logic [1:0]  exp_op;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [15:0] exp_disp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    board_cmd_sequencer #(
        .DEB_CYCLES(DEB),
        .TIMEOUT   (TMO),
        .AW        (8),
        .DW        (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_wr   (btn_wr),
        .btn_rd   (btn_rd),
        .btn_step (btn_step),
        .sw_addr  (sw_addr),
        .sw_data  (sw_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .disp_data(disp_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int sel, input logic v);
        case (sel)
            0: btn_wr = v;
            1: btn_rd = v;
            default: btn_step = v;
        endcase
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic cmd_t mk_cmd(input int sel, input logic [7:0] a, input logic [5:0] d);
        cmd_t c;
        case (sel)
            0: c = '{op: 2'b01, addr: {24'd0, a}, data: {26'd0, d}};
            1: c = '{op: 2'b10, addr: {24'd0, a}, data: {26'd0, d}};
            default: c = '{op: 2'b11, addr: 32'd0, data: 32'd0};
        endcase
        return c;
    endfunction

    // Scoreboard: every completed handshake must match the oldest expected command.
    always @(negedge clk) begin
        if (rst === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_cmd", {30'd0, cmd_op}, 32'd0);
            end else begin
                cmd_t e;
                e = sb.pop_front();
                chk("sb_op", {30'd0, cmd_op}, {30'd0, e.op});
                chk("sb_addr", cmd_addr, e.addr);
                chk("sb_data", cmd_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit seen;
        logic [1:0]  hold_op;
        logic [31:0] hold_data;

        vecs[0] = '{1, 8'h12, 6'h05, 0, 3, 16'hBEEF, 2'b10, 32'h12, 32'h05, 16'hBEEF, 1'b0};
        vecs[1] = '{0, 8'h34, 6'h2A, 5, 2, 16'h1234, 2'b01, 32'h34, 32'h2A, 16'h1234, 1'b0};
        vecs[2] = '{2, 8'hFF, 6'h3F, 0, -1, 16'h0000, 2'b11, 32'h00, 32'h00, 16'hEEEE, 1'b1};
        vecs[3] = '{1, 8'h80, 6'h01, 1, 0, 16'hCAFE, 2'b10, 32'h80, 32'h01, 16'hCAFE, 1'b0};
        vecs[4] = '{0, 8'h01, 6'h15, 0, 15, 16'hA5A5, 2'b01, 32'h01, 32'h15, 16'hA5A5, 1'b0};
        vecs[5] = '{2, 8'h77, 6'h22, 2, 1, 16'h0F0F, 2'b11, 32'h00, 32'h00, 16'h0F0F, 1'b0};

        rst = 1'b0;
        btn_wr = 0; btn_rd = 0; btn_step = 0;
        sw_addr = '0; sw_data = '0;
        cmd_ready = 0; rsp_valid = 0; rsp_data = '0;
        #1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_valid", {31'd0, cmd_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_disp", {16'd0, disp_data}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);

        // glitch shorter than the debounce window
        btn_rd = 1;
        repeat (3) tick();
        btn_rd = 0;
        seen = 0;
        repeat (15) begin
            tick();
            if (cmd_valid || busy) seen = 1;
        end
        chk("glitch_no_cmd", {31'd0, seen}, 32'd0);

        // table-driven transactions
        for (int v = 0; v < 6; v++) begin
            sw_addr   = vecs[v].addr;
            sw_data   = vecs[v].data;
            cmd_ready = (vecs[v].rdy_dly == 0);
            sb.push_back(mk_cmd(vecs[v].sel, vecs[v].addr, vecs[v].data));
            set_btn(vecs[v].sel, 1'b1);
            wait_valid(ok);
            set_btn(vecs[v].sel, 1'b0);
            chk("vec_valid_seen", {31'd0, ok}, 32'd1);
            chk("vec_op", {30'd0, cmd_op}, {30'd0, vecs[v].exp_op});
            chk("vec_addr", cmd_addr, vecs[v].exp_addr);
            chk("vec_data", cmd_data, vecs[v].exp_data);
            chk("vec_err_cleared", {31'd0, err}, 32'd0);
            hold_op   = cmd_op;
            hold_data = cmd_data;
            for (int k = 0; k < vecs[v].rdy_dly; k++) begin
                tick();
                chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
                chk("hold_op", {30'd0, cmd_op}, {30'd0, hold_op});
                chk("hold_data", cmd_data, hold_data);
            end
            cmd_ready = 1;
            tick();
            cmd_ready = 0;
            chk("accept_valid_low", {31'd0, cmd_valid}, 32'd0);
            chk("accept_op_nop", {30'd0, cmd_op}, 32'd0);
            chk("accept_busy", {31'd0, busy}, 32'd1);
            if (vecs[v].rsp_dly < 0) begin
                repeat (TMO - 1) tick();
                chk("tmo_pre_busy", {31'd0, busy}, 32'd1);
                chk("tmo_pre_err", {31'd0, err}, 32'd0);
                tick();
            end else begin
                repeat (vecs[v].rsp_dly) tick();
                chk("rsp_pre_busy", {31'd0, busy}, 32'd1);
                rsp_data  = vecs[v].rsp_val;
                rsp_valid = 1;
                tick();
                rsp_valid = 0;
                rsp_data  = 16'h0000;
            end
            chk("vec_disp", {16'd0, disp_data}, {16'd0, vecs[v].exp_disp});
            chk("vec_err", {31'd0, err}, {31'd0, vecs[v].exp_err});
            chk("vec_busy_done", {31'd0, busy}, 32'd0);
            repeat (10) tick();
        end

        // simultaneous write+read: write only; step during WAIT is dropped
        sw_addr = 8'h44;
        sw_data = 6'h11;
        cmd_ready = 1;
        sb.push_back(mk_cmd(0, 8'h44, 6'h11));
        btn_wr = 1;
        btn_rd = 1;
        wait_valid(ok);
        btn_wr = 0;
        btn_rd = 0;
        chk("arb_valid_seen", {31'd0, ok}, 32'd1);
        chk("arb_op_write", {30'd0, cmd_op}, 32'd1);
        tick();
        cmd_ready = 0;
        btn_step = 1;
        repeat (10) tick();
        btn_step = 0;
        chk("arb_still_wait", {31'd0, busy}, 32'd1);
        rsp_data = 16'h4321;
        rsp_valid = 1;
        tick();
        rsp_valid = 0;
        chk("arb_disp", {16'd0, disp_data}, 32'h4321);
        cmd_ready = 1;
        seen = 0;
        repeat (20) begin
            tick();
            if (cmd_valid || busy) seen = 1;
        end
        chk("drop_no_second_cmd", {31'd0, seen}, 32'd0);

        // asynchronous reset in the middle of WAIT
        sw_addr = 8'h56;
        sw_data = 6'h09;
        sb.push_back(mk_cmd(1, 8'h56, 6'h09));
        btn_rd = 1;
        wait_valid(ok);
        btn_rd = 0;
        chk("rst_valid_seen", {31'd0, ok}, 32'd1);
        tick();
        cmd_ready = 0;
        repeat (3) tick();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_disp", {16'd0, disp_data}, 32'd0);
        chk("arst_addr", cmd_addr, 32'd0);
        chk("arst_data", cmd_data, 32'd0);
        chk("arst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rsp_data = 16'h9999;
        rsp_valid = 1;
        tick();
        rsp_valid = 0;
        tick();
        chk("post_rst_disp", {16'd0, disp_data}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
